// File: rtl/eq_stim_driver_pkg.sv
// Shared types and constants for the equivalence stimulus driver and its LFSR.
// Holds the FSM state enum, the Galois tap mask, the zero-seed substitute and the LFSR step function.
package eq_stim_driver_pkg;

    localparam logic [31:0] LFSR_POLY     = 32'h80200003;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h00000001;
    localparam logic [31:0] CYC_CNT_MAX   = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Right-shifting Galois step: bit 0 is the output tap, fed back through the mask.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/eq_lfsr32.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1); a zero seed is replaced so the register never locks up.
// Latency: load/advance visible one cycle later; next_state exposes the value being written this cycle.
module eq_lfsr32
    import eq_stim_driver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [31:0] seed,
    output logic [31:0] state,
    output logic [31:0] next_state
);

    logic [31:0] seed_eff;
    logic [31:0] nxt;

    always_comb begin
        seed_eff = (seed == 32'h0) ? ZERO_SEED_SUB : seed;
        if (load) begin
            nxt = seed_eff;
        end else if (enable) begin
            nxt = lfsr_next(state);
        end else begin
            nxt = state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 32'h1;
        end else begin
            state <= nxt;
        end
    end

    assign next_state = nxt;

endmodule

// File: rtl/eq_stim_driver.sv
// Drives LFSR stimulus into an equivalence pair, skips a warm-up window, and captures the first mismatch.
// Latency: status one cycle after start; no backpressure, trigger/cmp_ok are sampled every RUN cycle.
module eq_stim_driver
    import eq_stim_driver_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 11,
    parameter int WARMUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [31:0]      max_cycles,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] cmp_ok,
    input  logic             trigger,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [31:0]      fail_cycle,
    output logic [N_OUT-1:0] fail_mask,
    output logic [N_IN-1:0]  fail_stim
);

    localparam logic [31:0] WARMUP_LAST = 32'(WARMUP - 1);

    state_t      st;
    logic [31:0] wu_cnt;
    logic [31:0] cyc_cnt;
    logic [31:0] max_q;
    logic        idle_like;
    logic        accept;
    logic        lfsr_en;
    logic [31:0] lfsr_state;
    logic [31:0] lfsr_nxt;
    logic        unused_lfsr_bits;

    assign idle_like = (st == ST_IDLE) || (st == ST_PASS) || (st == ST_FAIL);
    assign accept    = start && idle_like;
    assign lfsr_en   = (st == ST_WARMUP) || (st == ST_RUN);

    eq_lfsr32 u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .enable     (lfsr_en),
        .seed       (seed),
        .state      (lfsr_state),
        .next_state (lfsr_nxt)
    );

    // Only the low bits reach the stimulus bus; the rest of the register is internal.
    assign unused_lfsr_bits = ^{lfsr_state, lfsr_nxt[31:N_IN]};

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            stim       <= '0;
            wu_cnt     <= '0;
            cyc_cnt    <= '0;
            max_q      <= '0;
            fail_cycle <= '0;
            fail_mask  <= '0;
            fail_stim  <= '0;
        end else begin
            // stim tracks the LFSR register so it always shows the value the pair is seeing.
            if (accept || lfsr_en) begin
                stim <= lfsr_nxt[N_IN-1:0];
            end

            case (st)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        max_q      <= max_cycles;
                        wu_cnt     <= '0;
                        cyc_cnt    <= '0;
                        fail_cycle <= '0;
                        fail_mask  <= '0;
                        fail_stim  <= '0;
                        if (max_cycles == 32'h0) begin
                            st <= ST_PASS;
                        end else if (WARMUP == 0) begin
                            st <= ST_RUN;
                        end else begin
                            st <= ST_WARMUP;
                        end
                    end
                end

                ST_WARMUP: begin
                    if (wu_cnt == WARMUP_LAST) begin
                        st <= ST_RUN;
                    end else begin
                        wu_cnt <= wu_cnt + 32'd1;
                    end
                end

                ST_RUN: begin
                    if (trigger) begin
                        st         <= ST_FAIL;
                        fail_cycle <= cyc_cnt;
                        fail_mask  <= ~cmp_ok;
                        fail_stim  <= stim;
                    end else begin
                        if (cyc_cnt == max_q - 32'd1) begin
                            st <= ST_PASS;
                        end
                        if (cyc_cnt != CYC_CNT_MAX) begin
                            cyc_cnt <= cyc_cnt + 32'd1;
                        end
                    end
                end

                default: st <= ST_IDLE;
            endcase
        end
    end

    assign busy = (st == ST_WARMUP) || (st == ST_RUN);
    assign done = (st == ST_PASS) || (st == ST_FAIL);
    assign fail = (st == ST_FAIL);

endmodule

// File: doc/eq_stim_driver.md
EQ_STIM_DRIVER -- requirements
Module: eq_stim_driver

Interface
REQ-001 Parameter N_IN, default 3: number of stimulus bits driven into both netlists of the equivalence pair.
REQ-002 Parameter N_OUT, default 11: number of per-output equality flags returned by the equivalence top.
REQ-003 Parameter WARMUP, default 4: cycles after run start during which mismatches are ignored so netlist flops can settle.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse that arms a run; honoured only in IDLE, PASS or FAIL.
REQ-007 seed  in  32  LFSR seed, sampled on an accepted start.
REQ-008 max_cycles  in  32  compared-cycle budget, sampled on an accepted start.
REQ-009 stim  out  N_IN  registered stimulus; drives the shared data inputs of the equivalence top.
REQ-010 cmp_ok  in  N_OUT  per-output equality flags from the equivalence top, 1 = equal.
REQ-011 trigger  in  1  mismatch indication from the equivalence top, 1 = not equivalent.
REQ-012 busy  out  1  high in WARMUP and RUN.
REQ-013 done  out  1  high in PASS or FAIL.
REQ-014 fail  out  1  high in FAIL only.
REQ-015 fail_cycle  out  32  compared-cycle index of the first mismatch.
REQ-016 fail_mask  out  N_OUT  ~cmp_ok captured at the first mismatch.
REQ-017 fail_stim  out  N_IN  stim value applied in the failing cycle.

Function
REQ-018 FSM states: IDLE, WARMUP, RUN, PASS, FAIL; one-hot or binary encoding is free.
REQ-019 IDLE/PASS/FAIL + start: load the LFSR with seed (0 is replaced by 32'h1), clear cyc_cnt and the capture registers, go to WARMUP; if max_cycles == 0, go directly to PASS instead.
REQ-020 The LFSR is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advancing once per cycle in WARMUP and RUN; stim = lfsr[N_IN-1:0], registered.
REQ-021 WARMUP lasts exactly WARMUP cycles, with trigger ignored, then goes to RUN; WARMUP = 0 goes straight to RUN.
REQ-022 RUN: each cycle samples trigger against the stim currently on the output; cyc_cnt counts RUN cycles from 0.
REQ-023 RUN with trigger = 1: go to FAIL and capture fail_cycle = cyc_cnt, fail_mask = ~cmp_ok, fail_stim = stim, all in the same edge.
REQ-024 RUN with cyc_cnt == max_cycles-1 and trigger = 0: go to PASS.
REQ-025 trigger = 1 on the final budgeted cycle: FAIL wins over PASS.
REQ-026 In PASS and FAIL, the LFSR, stim and captures hold.
REQ-027 start while busy is ignored.
REQ-028 cyc_cnt saturates at 32'hFFFFFFFF and never wraps.

Reset
REQ-029 While rst is high at a clock edge: state = IDLE; lfsr = 32'h1; stim = 0; cyc_cnt, fail_cycle, fail_mask and fail_stim = 0; busy, done and fail = 0.
REQ-030 rst asserted mid-run aborts the run with no partial capture retained; start in the same cycle as rst is ignored.

Structure
REQ-031 A shared package holds the FSM state enum, the LFSR polynomial constant (32'h80200003) and the zero-seed substitute constant.
REQ-032 One sub-module, eq_lfsr32, holds the LFSR, with load, enable, seed and state ports; all FSM and capture logic stays in eq_stim_driver.

Verification
REQ-033 Bench instantiates eq_stim_driver with a model equivalence pair whose mismatch can be forced at a chosen stim value and cycle.
REQ-034 Test 1: seed = 1, max_cycles = 100, no mismatch -> busy for 104 cycles, then done = 1, fail = 0, and the stim sequence matches the reference LFSR model.
REQ-035 Test 2: force mismatch on output 3 at RUN cycle 17 -> fail = 1, fail_cycle = 17, fail_mask = 11'h008, and fail_stim equals the model's stim at cycle 17.
REQ-036 Test 3: trigger forced high during WARMUP only -> ignored; run ends in PASS.
REQ-037 Test 4: max_cycles = 5 with mismatch on cycle 4 -> FAIL, fail_cycle = 4; repeat with max_cycles = 0 -> PASS one cycle after start.
REQ-038 Test 5: rst pulsed at RUN cycle 10 -> all outputs 0, state IDLE; a new start with seed 0 produces the same stim sequence as seed 1.
